xs3_bcd_serial_converter: RTL and testbench

Multi-digit, bidirectional Excess-3 / BCD code converter for the DLD lab datapath. It converts a packed word of DIGITS 4-bit codes one digit per clock, least-significant digit first, under a start/done handshake. It flags digits that are illegal in the selected source code. It supersedes the single-digit combinational Excess-3 to BCD converter and adds width parametrisation, a BCD to Excess-3 mode, invalid-code detection and sequencing.

---
 rtl/xs3_bcd_serial_converter.sv | 126 ++++++++++++
 tb/tb_xs3_bcd_serial_converter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xs3_bcd_serial_converter.sv
// xs3_bcd_serial_converter
// Converts a packed word of DIGITS 4-bit codes one digit per clock, LSD first.
// Mode 0 converts Excess-3 to BCD. Mode 1 converts BCD to Excess-3.
// An illegal source digit produces 1111 and sets its err_mask bit.
// Starts use a start/busy/done handshake. A new start is also accepted in the DONE cycle.
module xs3_bcd_serial_converter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] dout,
    output logic [DIGITS-1:0]   err_mask,
    output logic                err,
    output logic                busy,
    output logic                done
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] src;
    logic                mode_r;
    logic [CNT_W-1:0]    cnt;

    logic [3:0]          cur_digit;
    logic [3:0]          conv_val;
    logic                conv_bad;
    logic [4*DIGITS-1:0] dout_next;
    logic [DIGITS-1:0]   mask_next;
    logic                accept;

    // Returns {illegal, converted}. An illegal code yields 1111.
    function automatic logic [4:0] convert_digit(input logic m, input logic [3:0] d);
        logic [4:0] r;
        if (!m) begin
            if (d >= 4'd3 && d <= 4'd12)
                r = {1'b0, d - 4'd3};
            else
                r = 5'b1_1111;
        end else begin
            if (d <= 4'd9)
                r = {1'b0, d + 4'd3};
            else
                r = 5'b1_1111;
        end
        return r;
    endfunction

    // Select the current digit, convert it, and merge it into the next dout and err_mask.
    always_comb begin
        cur_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i))
                cur_digit = src[4*i +: 4];
        end
        {conv_bad, conv_val} = convert_digit(mode_r, cur_digit);
        dout_next = dout;
        mask_next = err_mask;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt == CNT_W'(i)) begin
                dout_next[4*i +: 4] = conv_val;
                mask_next[i]        = conv_bad;
            end
        end
        accept = start && (state == IDLE || state == DONE);
    end

    // Sequencer: latch the request, walk the digits, and produce a one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= '0;
            mode_r   <= 1'b0;
            cnt      <= '0;
            dout     <= '0;
            err_mask <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (accept) begin
            state    <= CONV;
            src      <= din;
            mode_r   <= mode;
            cnt      <= '0;
            dout     <= '0;
            err_mask <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                CONV: begin
                    dout     <= dout_next;
                    err_mask <= mask_next;
                    if (cnt == LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                        err   <= |mask_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xs3_bcd_serial_converter.sv
// Bench for xs3_bcd_serial_converter.
// Instance dut has DIGITS=4 and its results are checked by a scoreboard at done.
// Instance dut1 has DIGITS=1 and is used for the full code sweep.
module tb_xs3_bcd_serial_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] din;
    logic [15:0] dout;
    logic [3:0]  err_mask;
    logic        err;
    logic        busy;
    logic        done;

    logic        start1;
    logic        mode1;
    logic [3:0]  din1;
    logic [3:0]  dout1;
    logic [0:0]  err_mask1;
    logic        err1;
    logic        busy1;
    logic        done1;

    always #5 clk = ~clk;

    xs3_bcd_serial_converter #(.DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .din(din),
        .dout(dout), .err_mask(err_mask), .err(err), .busy(busy), .done(done)
    );

    xs3_bcd_serial_converter #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .din(din1),
        .dout(dout1), .err_mask(err_mask1), .err(err1), .busy(busy1), .done(done1)
    );

    typedef struct {
        logic        m;
        logic [15:0] din;
        logic [15:0] dout;
        logic [3:0]  mask;
        logic        err;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    vec_t sb_q[$];
    vec_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference mapping for one digit. Returns {illegal, code}.
    function automatic logic [4:0] ref_digit(input logic m, input logic [3:0] d);
        int v;
        v = int'(d);
        if (!m) return (v >= 3 && v <= 12) ? {1'b0, 4'(v - 3)} : 5'h1F;
        return (v <= 9) ? {1'b0, 4'(v + 3)} : 5'h1F;
    endfunction

    function automatic vec_t model_word(input logic m, input logic [15:0] d);
        vec_t       e;
        logic [4:0] r;
        e.m = m;
        e.din = d;
        e.dout = '0;
        e.mask = '0;
        for (int i = 0; i < 4; i++) begin
            r = ref_digit(m, d[4*i +: 4]);
            e.dout[4*i +: 4] = r[3:0];
            e.mask[i] = r[4];
        end
        e.err = |e.mask;
        return e;
    endfunction

    // Scoreboard monitor: each done pops one expected word; busy and done must never overlap.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_overlap", 32'(busy & done), 32'd0);
            if (done) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("sb_dout", 32'(dout), 32'(mon_e.dout));
                    check("sb_err_mask", 32'(err_mask), 32'(mon_e.mask));
                    check("sb_err", 32'(err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic launch(input logic m, input logic [15:0] d, input vec_t e);
        mode = m;
        din = d;
        start = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({name, "_timeout"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check({name, "_dout"}, 32'(dout), 32'd0);
        check({name, "_mask"}, 32'(err_mask), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        int   dc;
        vec_t e;
        logic [4:0] r;

        tbl[0] = '{m: 1'b0, din: 16'h3C47, dout: 16'h0914, mask: 4'b0000, err: 1'b0};
        tbl[1] = '{m: 1'b1, din: 16'h1995, dout: 16'h4CC8, mask: 4'b0000, err: 1'b0};
        tbl[2] = '{m: 1'b0, din: 16'h4CC8, dout: 16'h1995, mask: 4'b0000, err: 1'b0};
        tbl[3] = '{m: 1'b0, din: 16'h3A0F, dout: 16'h07FF, mask: 4'b0011, err: 1'b1};
        tbl[4] = '{m: 1'b1, din: 16'h9A00, dout: 16'hCF33, mask: 4'b0100, err: 1'b1};
        tbl[5] = '{m: 1'b1, din: 16'hFB90, dout: 16'hFFC3, mask: 4'b1100, err: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        din = '0;
        start1 = 1'b0;
        mode1 = 1'b0;
        din1 = '0;

        // Reset state, and stability while idle
        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_zero("idle");
        end
        @(posedge clk);
        #1;

        // Handshake timing with an intermediate dout value
        mode = 1'b0;
        din = 16'h3C47;
        start = 1'b1;
        sb_q.push_back(tbl[0]);
        dc = done_count;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t_busy_e0", 32'(busy), 32'd1);
        check("t_dout_e0", 32'(dout), 32'd0);
        @(negedge clk);
        check("t_dout_e1", 32'(dout), 32'h0004);
        check("t_busy_e1", 32'(busy), 32'd1);
        @(negedge clk);
        check("t_busy_e2", 32'(busy), 32'd1);
        @(negedge clk);
        check("t_busy_e3", 32'(busy), 32'd1);
        check("t_done_e3", 32'(done), 32'd0);
        @(negedge clk);
        check("t_busy_e4", 32'(busy), 32'd0);
        check("t_done_e4", 32'(done), 32'd1);
        @(negedge clk);
        check("t_done_e5", 32'(done), 32'd0);
        check("t_hold_dout", 32'(dout), 32'h0914);
        check("t_done_count", 32'(done_count - dc), 32'd1);
        @(posedge clk);
        #1;

        // Table-driven words, plus a few random ones
        for (int i = 0; i < 6; i++) begin
            launch(tbl[i].m, tbl[i].din, tbl[i]);
            wait_drain("table");
        end
        for (int i = 0; i < 4; i++) begin
            logic        m;
            logic [15:0] d;
            m = 1'(i);
            d = 16'($urandom);
            launch(m, d, model_word(m, d));
            wait_drain("random");
        end

        // Back-to-back: a second start issued in the DONE cycle
        dc = done_count;
        launch(1'b1, 16'h1995, tbl[1]);
        repeat (4) @(posedge clk);
        #1;
        check("b2b_in_done", 32'(done), 32'd1);
        mode = 1'b0;
        din = 16'h4CC8;
        start = 1'b1;
        sb_q.push_back(tbl[2]);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy_again", 32'(busy), 32'd1);
        check("b2b_done_low", 32'(done), 32'd0);
        wait_drain("b2b");
        check("b2b_done_count", 32'(done_count - dc), 32'd2);

        // A start pulse while busy is ignored
        dc = done_count;
        launch(1'b0, 16'h3C47, tbl[0]);
        @(posedge clk);
        #1;
        mode = 1'b1;
        din = 16'h1995;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain("busy_ign");
        repeat (3) @(posedge clk);
        #1;
        check("busy_ign_done_count", 32'(done_count - dc), 32'd1);

        // Reset asserted after E2 clears everything and suppresses done
        launch(1'b0, 16'h3C47, tbl[0]);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        dc = done_count;
        repeat (6) @(negedge clk);
        check("midrst_no_done", 32'(done_count - dc), 32'd0);
        @(posedge clk);
        #1;
        launch(1'b0, 16'h3A0F, tbl[3]);
        wait_drain("after_rst");

        // DIGITS=1 sweep of all codes in both modes
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 16; c++) begin
                mode1 = 1'(m);
                din1 = 4'(c);
                start1 = 1'b1;
                r = ref_digit(1'(m), 4'(c));
                @(posedge clk);
                #1;
                start1 = 1'b0;
                check("d1_busy", 32'(busy1), 32'd1);
                @(posedge clk);
                #1;
                check("d1_done", 32'(done1), 32'd1);
                check("d1_dout", 32'(dout1), 32'(r[3:0]));
                check("d1_mask", 32'(err_mask1), 32'(r[4]));
                check("d1_err", 32'(err1), 32'(r[4]));
                @(posedge clk);
                #1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
